// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data RAM arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;
    localparam int RAM_AW = 10;
    localparam int RD_LAT_DEFAULT = 1;
    function automatic logic addr_oob(input logic [31:0] a);
        return |a[31:RAM_AW];
    endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational owner selector; MEM_ARB_RR_EN selects round-robin, else MEM has fixed priority
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
    input  owner_t last_owner,
    output logic   valid,
    output owner_t owner
);
    assign valid = if_req | mem_req;
`ifdef MEM_ARB_RR_EN
    assign owner = (if_req && mem_req) ? ((last_owner == OWN_IF) ? OWN_MEM : OWN_IF)
                                       : (mem_req ? OWN_MEM : OWN_IF);
`else
    logic unused_last;
    assign unused_last = last_owner;
    assign owner = mem_req ? OWN_MEM : OWN_IF;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data-stage ports onto one synchronous single-port RAM
// Round-robin contention when MEM_ARB_RR_EN is defined, fixed MEM priority otherwise.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              addr_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t            state, state_n;
    owner_t            owner, owner_n, last_owner, last_n, pick_owner;
    logic              pick_valid;
    logic [2:0]        cnt, cnt_n;
    logic              we_q, we_n, flushed, flushed_n;
    logic              if_gnt_n, if_rvalid_n, mem_gnt_n, mem_rvalid_n, addr_err_n;
    logic              ram_en_n, ram_we_n;
    logic [RAM_AW-1:0] ram_addr_n;
    logic [31:0]       ram_wdata_n, if_rdata_n, mem_rdata_n, sel_addr;

    arb_pick u_pick (
        .if_req    (if_req),
        .mem_req   (mem_req),
        .last_owner(last_owner),
        .valid     (pick_valid),
        .owner     (pick_owner)
    );

    assign sel_addr = (pick_owner == OWN_MEM) ? mem_addr : if_addr;

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        owner_n      = owner;
        last_n       = last_owner;
        we_n         = we_q;
        flushed_n    = flushed;
        if_gnt_n     = 1'b0;
        mem_gnt_n    = 1'b0;
        if_rvalid_n  = 1'b0;
        mem_rvalid_n = 1'b0;
        addr_err_n   = 1'b0;
        ram_en_n     = 1'b0;
        ram_we_n     = 1'b0;
        ram_addr_n   = ram_addr;
        ram_wdata_n  = ram_wdata;
        if_rdata_n   = if_rdata;
        mem_rdata_n  = mem_rdata;
        unique case (state)
            IDLE: if (pick_valid) begin
                state_n     = ISSUE;
                owner_n     = pick_owner;
                last_n      = pick_owner;
                we_n        = (pick_owner == OWN_MEM) && mem_we;
                flushed_n   = 1'b0;
                cnt_n       = '0;
                if_gnt_n    = pick_owner == OWN_IF;
                mem_gnt_n   = pick_owner == OWN_MEM;
                ram_en_n    = 1'b1;
                ram_we_n    = (pick_owner == OWN_MEM) && mem_we;
                ram_addr_n  = sel_addr[RAM_AW-1:0];
                ram_wdata_n = (pick_owner == OWN_MEM) ? mem_wdata : ram_wdata;
                addr_err_n  = addr_oob(sel_addr);
            end
            ISSUE: begin
                state_n   = we_q ? IDLE : WAIT;
                flushed_n = flushed | (if_flush & (owner == OWN_IF));
            end
            WAIT: if (cnt == LAT) begin
                state_n = IDLE;
                cnt_n   = '0;
                if (owner == OWN_MEM) begin
                    mem_rdata_n  = ram_rdata;
                    mem_rvalid_n = 1'b1;
                end else if (!(flushed || if_flush)) begin
                    if_rdata_n  = ram_rdata;
                    if_rvalid_n = 1'b1;
                end
            end else begin
                cnt_n     = cnt + 3'd1;
                flushed_n = flushed | (if_flush & (owner == OWN_IF));
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            we_q       <= 1'b0;
            flushed    <= 1'b0;
            if_gnt     <= 1'b0;
            mem_gnt    <= 1'b0;
            if_rvalid  <= 1'b0;
            mem_rvalid <= 1'b0;
            addr_err   <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            owner      <= owner_n;
            last_owner <= last_n;
            we_q       <= we_n;
            flushed    <= flushed_n;
            if_gnt     <= if_gnt_n;
            mem_gnt    <= mem_gnt_n;
            if_rvalid  <= if_rvalid_n;
            mem_rvalid <= mem_rvalid_n;
            addr_err   <= addr_err_n;
            ram_en     <= ram_en_n;
            ram_we     <= ram_we_n;
            ram_addr   <= ram_addr_n;
            ram_wdata  <= ram_wdata_n;
            if_rdata   <= if_rdata_n;
            mem_rdata  <= mem_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench; instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic if_req = 1'b0, if_flush = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic if_gnt [2], if_rvalid [2], mem_gnt [2], mem_rvalid [2], addr_err [2], ram_en [2], ram_we [2];
    logic [31:0] if_rdata [2], mem_rdata [2], ram_wdata [2];
    logic [9:0] ram_addr [2];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // RAM model: preloaded with ram[a] = a + 2, read data appears LAT edges after sampling and holds
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] ram [1024];
        logic [31:0] pipe [LAT];
        logic [31:0] rd;
        assign rd = pipe[LAT-1];
        always @(posedge clk) begin
            if (!rst_n) for (int i = 0; i < 1024; i++) ram[i] <= 32'(i + 2);
            else if (ram_en[g] && ram_we[g]) ram[ram_addr[g]] <= ram_wdata[g];
            if (ram_en[g] && !ram_we[g]) pipe[0] <= ram[ram_addr[g]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        mem_arbiter #(.RD_LAT(LAT)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
            .if_gnt(if_gnt[g]), .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_gnt(mem_gnt[g]), .mem_rvalid(mem_rvalid[g]), .mem_rdata(mem_rdata[g]),
            .addr_err(addr_err[g]), .ram_en(ram_en[g]), .ram_we(ram_we[g]),
            .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_rdata(rd)
        );
    end

    function automatic logic [112:0] outs(input int g);
        return {if_gnt[g], if_rvalid[g], mem_gnt[g], mem_rvalid[g], addr_err[g], ram_en[g], ram_we[g],
                ram_addr[g], ram_wdata[g], if_rdata[g], mem_rdata[g]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (outs(0) !== '0) begin failures++; $display("FAIL reset_outs0: got %h want 0", outs(0)); end
        checks++;
        if (outs(1) !== '0) begin failures++; $display("FAIL reset_outs1: got %h want 0", outs(1)); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (outs(0) !== '0) begin failures++; $display("FAIL idle_outs: got %h want 0", outs(0)); end
    endtask

    task automatic test_single_read();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd3;
        tick();
        checks++;
        if ({mem_gnt[0], if_gnt[0], ram_en[0], ram_we[0], addr_err[0], ram_addr[0]} !== {5'b10100, 10'd3}) begin
            failures++; $display("FAIL rd_issue: got %b want 10100_0000000011",
                {mem_gnt[0], if_gnt[0], ram_en[0], ram_we[0], addr_err[0], ram_addr[0]});
        end
        mem_req = 1'b0;
        tick();
        checks++;
        if ({mem_gnt[0], ram_en[0], mem_rvalid[0]} !== 3'b000) begin
            failures++; $display("FAIL rd_wait: got %b want 000", {mem_gnt[0], ram_en[0], mem_rvalid[0]});
        end
        tick();
        checks++;
        if (mem_rvalid[0] !== 1'b0) begin failures++; $display("FAIL rd_early: got %b want 0", mem_rvalid[0]); end
        tick();
        checks++;
        if ({mem_rvalid[0], mem_rdata[0]} !== {1'b1, 32'd5}) begin
            failures++; $display("FAIL rd_data: got %b/%h want 1/00000005", mem_rvalid[0], mem_rdata[0]);
        end
        tick();
        checks++;
        if ({mem_rvalid[0], mem_rdata[0]} !== {1'b0, 32'd5}) begin
            failures++; $display("FAIL rd_hold: got %b/%h want 0/00000005", mem_rvalid[0], mem_rdata[0]);
        end
    endtask

    task automatic test_write_then_read();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'd2; mem_wdata = 32'h6D;
        tick();
        checks++;
        if ({mem_gnt[0], ram_en[0], ram_we[0], ram_addr[0], ram_wdata[0]} !== {3'b111, 10'd2, 32'h6D}) begin
            failures++; $display("FAIL wr_issue: got %b %h %h want 111 002 0000006d",
                {mem_gnt[0], ram_en[0], ram_we[0]}, ram_addr[0], ram_wdata[0]);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        checks++;
        if ({mem_gnt[0], ram_en[0], mem_rvalid[0]} !== 3'b000) begin
            failures++; $display("FAIL wr_done: got %b want 000", {mem_gnt[0], ram_en[0], mem_rvalid[0]});
        end
        if_req = 1'b1; if_addr = 32'd2;
        tick();
        checks++;
        if ({if_gnt[0], mem_gnt[0], ram_we[0]} !== 3'b100) begin
            failures++; $display("FAIL if_gnt: got %b want 100", {if_gnt[0], mem_gnt[0], ram_we[0]});
        end
        if_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({if_rvalid[0], mem_rvalid[0]} !== 2'b00) begin
            failures++; $display("FAIL if_early: got %b want 00", {if_rvalid[0], mem_rvalid[0]});
        end
        tick();
        checks++;
        if ({if_rvalid[0], mem_rvalid[0], if_rdata[0]} !== {2'b10, 32'h6D}) begin
            failures++; $display("FAIL if_rdata: got %b%b/%h want 10/0000006d", if_rvalid[0], mem_rvalid[0], if_rdata[0]);
        end
        tick();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'd3;
        tick();
        if_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({if_rvalid[0], if_rdata[0]} !== {1'b1, 32'd5}) begin
            failures++; $display("FAIL pre_flush_rd: got %b/%h want 1/00000005", if_rvalid[0], if_rdata[0]);
        end
        if_flush = 1'b1;
        tick();
        if_req = 1'b1; if_addr = 32'd0;
        tick();
        if_req = 1'b0; if_flush = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({if_rvalid[0], if_rdata[0]} !== {1'b1, 32'd2}) begin
            failures++; $display("FAIL idle_flush: got %b/%h want 1/00000002", if_rvalid[0], if_rdata[0]);
        end
        if_req = 1'b1; if_addr = 32'd1;
        tick();
        checks++;
        if ({if_gnt[0], ram_en[0], ram_addr[0]} !== {2'b11, 10'd1}) begin
            failures++; $display("FAIL flush_issue: got %b%b/%h want 11/001", if_gnt[0], ram_en[0], ram_addr[0]);
        end
        if_req = 1'b0;
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        tick();
        checks++;
        if ({if_rvalid[0], if_rdata[0]} !== {1'b0, 32'd2}) begin
            failures++; $display("FAIL flush_suppress: got %b/%h want 0/00000002", if_rvalid[0], if_rdata[0]);
        end
        tick();
        checks++;
        if (if_rvalid[0] !== 1'b0) begin failures++; $display("FAIL flush_late: got %b want 0", if_rvalid[0]); end
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd1; if_flush = 1'b1;
        tick();
        mem_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({mem_rvalid[0], mem_rdata[0], if_rvalid[0]} !== {1'b1, 32'd3, 1'b0}) begin
            failures++; $display("FAIL mem_flush: got %b/%h/%b want 1/00000003/0", mem_rvalid[0], mem_rdata[0], if_rvalid[0]);
        end
        if_flush = 1'b0;
        tick();
    endtask

    task automatic test_addr_err();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h401;
        tick();
        checks++;
        if ({mem_gnt[0], addr_err[0], ram_addr[0]} !== {2'b11, 10'd1}) begin
            failures++; $display("FAIL oob_issue: got %b%b/%h want 11/001", mem_gnt[0], addr_err[0], ram_addr[0]);
        end
        mem_req = 1'b0;
        tick();
        checks++;
        if (addr_err[0] !== 1'b0) begin failures++; $display("FAIL oob_pulse: got %b want 0", addr_err[0]); end
        tick(); tick();
        checks++;
        if ({mem_rvalid[0], mem_rdata[0]} !== {1'b1, 32'd3}) begin
            failures++; $display("FAIL oob_data: got %b/%h want 1/00000003", mem_rvalid[0], mem_rdata[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd3;
        tick();
        checks++;
        if (mem_gnt[0] !== 1'b1) begin failures++; $display("FAIL b2b_gnt1: got %b want 1", mem_gnt[0]); end
        tick(); tick(); tick();
        checks++;
        if ({mem_gnt[0], mem_rvalid[0]} !== 2'b01) begin
            failures++; $display("FAIL b2b_rvalid: got %b want 01", {mem_gnt[0], mem_rvalid[0]});
        end
        tick();
        checks++;
        if ({mem_gnt[0], mem_rvalid[0]} !== 2'b10) begin
            failures++; $display("FAIL b2b_gnt2: got %b want 10", {mem_gnt[0], mem_rvalid[0]});
        end
        mem_req = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (mem_rvalid[0] !== 1'b1) begin failures++; $display("FAIL b2b_rvalid2: got %b want 1", mem_rvalid[0]); end
        tick();
    endtask

    task automatic test_contention();
        int seq [4];
        int exp [4];
        int n = 0;
        int both = 0;
`ifdef MEM_ARB_RR_EN
        exp = '{1, 0, 1, 0};
`else
        exp = '{1, 1, 1, 1};
`endif
        do_reset();
        if_req = 1'b1; if_addr = 32'd0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'd5; mem_wdata = 32'd7;
        for (int c = 0; c < 60 && n < 4; c++) begin
            tick();
            if (if_gnt[0] && mem_gnt[0]) both++;
            if (mem_gnt[0]) begin seq[n] = 1; n++; end
            else if (if_gnt[0]) begin seq[n] = 0; n++; end
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        checks++;
        if (n !== 4) begin failures++; $display("FAIL arb_count: got %0d grants want 4", n); end
        checks++;
        if (both !== 0) begin failures++; $display("FAIL arb_double: got %0d want 0", both); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (seq[k] !== exp[k]) begin
                failures++; $display("FAIL arb_order%0d: got %0d want %0d (1=MEM)", k, seq[k], exp[k]);
            end
        end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'd3;
        tick();
        checks++;
        if (mem_gnt[1] !== 1'b1) begin failures++; $display("FAIL lat3_gnt: got %b want 1", mem_gnt[1]); end
        mem_req = 1'b0;
        repeat (4) tick();
        checks++;
        if (mem_rvalid[1] !== 1'b0) begin failures++; $display("FAIL lat3_early: got %b want 0", mem_rvalid[1]); end
        tick();
        checks++;
        if ({mem_rvalid[1], mem_rdata[1]} !== {1'b1, 32'd5}) begin
            failures++; $display("FAIL lat3_data: got %b/%h want 1/00000005", mem_rvalid[1], mem_rdata[1]);
        end
        tick();
        mem_req = 1'b1; mem_addr = 32'd0;
        tick();
        mem_req = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs(1) !== '0) begin failures++; $display("FAIL async_reset: got %h want 0", outs(1)); end
        tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            if (mem_rvalid[1] || if_rvalid[1]) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL stale_rvalid: got %0d pulses want 0", seen); end
        if_req = 1'b1; if_addr = 32'd0; mem_req = 1'b1; mem_addr = 32'd3;
        tick();
        checks++;
        if ({mem_gnt[1], if_gnt[1]} !== 2'b10) begin
            failures++; $display("FAIL post_reset_arb: got %b want 10", {mem_gnt[1], if_gnt[1]});
        end
        if_req = 1'b0; mem_req = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_then_read();
        test_flush();
        test_addr_err();
        test_back_to_back();
        test_contention();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, SHALL set RAM read latency in cycles (legal 1..4).
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch read request; held, with if_addr stable, until if_gnt.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_flush  input  1  cancels the in-flight fetch response.
REQ-007 if_gnt / if_rvalid  output  1 each  fetch accepted / fetch data valid (one-cycle pulses).
REQ-008 if_rdata  output  32  fetch read data.
REQ-009 mem_req, mem_we  input  1 each  data-stage request; write when mem_we=1.
REQ-010 mem_addr, mem_wdata  input  32 each  data-stage word address, write data.
REQ-011 mem_gnt / mem_rvalid  output  1 each  data access accepted / read data valid (pulses).
REQ-012 mem_rdata  output  32  data-stage read data.
REQ-013 addr_err  output  1  one-cycle pulse: granted address has bits [31:10] nonzero.
REQ-014 ram_en, ram_we  output  1 each; ram_addr  output  10; ram_wdata  output  32; ram_rdata  input  32  single-port 1K x 32 synchronous RAM.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT; one RAM access in flight at most.
REQ-016 IDLE with any request: pick owner, latch addr/we/wdata, go ISSUE; grant and ram_en/ram_* SHALL be registered, high for exactly the ISSUE cycle.
REQ-017 ram_addr SHALL be granted address [9:0]; out-of-range address still accessed (wraps) and addr_err pulses in ISSUE.
REQ-018 Write: ISSUE -> IDLE; no rvalid pulse.
REQ-019 Read: ISSUE -> WAIT; counter SHALL count RD_LAT cycles, then capture ram_rdata into owner rdata, pulse owner rvalid next cycle, return IDLE.
REQ-020 Read latency: request sampled at edge E0 -> rvalid high in cycle after edge E0+RD_LAT+2.
REQ-021 rvalid-pulse cycle is IDLE; a new request SHALL be sampled that same edge.
REQ-022 Contention (both req in IDLE) resolved per REQ-029/030; loser's gnt stays low (stall) until served.
REQ-023 if_flush high any cycle from ISSUE through capture of an IF read SHALL suppress if_rvalid; RAM access still completes; if_rdata not updated.
REQ-024 if_flush with no IF read in flight, or during a MEM access, SHALL have no effect.
REQ-025 rdata registers SHALL hold last value between reads; requests deasserted in IDLE -> remain IDLE, all pulses low.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter 0, all outputs 0 (including rdata), last-owner = IF.
REQ-027 Reset mid-access SHALL abandon the transaction; no rvalid after release.
REQ-028 First contention after reset SHALL grant MEM.

Configuration
REQ-029 Macro MEM_ARB_RR_EN defined: round-robin under contention, grant requester not granted last; last-owner updated on each grant.
REQ-030 Macro undefined: fixed priority, MEM always wins contention; IF served only when mem_req low.

Structure
REQ-031 Package mem_arb_pkg SHALL hold state enum, owner enum (OWN_IF, OWN_MEM), RAM_AW=10, RD_LAT_DEFAULT=1.
REQ-032 Sub-module arb_pick SHALL be the combinational owner selector (inputs: both reqs, last-owner; holds MEM_ARB_RR_EN logic).

Verification
REQ-033 RD_LAT=1, mem read addr 3 (RAM[3]=5) -> mem_gnt in ISSUE, mem_rvalid with mem_rdata=5 three edges after sample, ram_we=0.
REQ-034 Mem write addr 2 data 0x6D, then IF read addr 2 -> no mem_rvalid; if_rdata=0x6D.
REQ-035 Both reqs held for 4 accesses: RR -> MEM,IF,MEM,IF; fixed -> MEM x4, if_gnt low throughout.
REQ-036 IF read addr 1, if_flush in WAIT -> ram_en pulse occurs, if_rvalid stays 0, if_rdata unchanged.
REQ-037 mem read addr 0x401 -> ram_addr=1, addr_err pulse in ISSUE, mem_rdata=RAM[1].
REQ-038 rst_n low during WAIT (RD_LAT=3) -> outputs 0 at once, no rvalid after release, next contention grants MEM.
